// File: rtl/lut_ff_mux_pkg.sv
// Shared types for the lut_ff_mux round-robin scheduler.
// Holds the operand width, the FSM state encoding and the response record.
package lut_ff_mux_pkg;

  localparam int OPER_W   = 4;
  localparam int ID_MAX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic                q;
  } rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping from N-1 back to 0.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(N);

  int j;

  // Walk offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    j       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        gnt     = '0;
        gnt[j]  = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/lut_ff_mux_sched.sv
// Round-robin scheduler sharing one lut_ff_mux datapath between N_REQ requesters;
// returns the sampled Q with the requester ID over a valid/ready channel.
//
// state | meaning
// IDLE  | arbitrate; accept one request (blocked while dp_rst is high)
// DRIVE | operand and mode on the datapath; combinational result sampled here
// WAIT  | registered mode only: datapath FF has loaded, result sampled here
// RESP  | rsp_valid high until rsp_ready
module lut_ff_mux_sched
  import lut_ff_mux_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*OPER_W-1:0]  req_in,
  input  logic [N_REQ-1:0]         req_reg,
  output logic [N_REQ-1:0]         req_ready,
  output logic [OPER_W-1:0]        dp_in,
  output logic                     dp_mux_sel,
  output logic                     dp_rst,
  input  logic                     dp_q,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic                     rsp_q,
  output logic                     busy,
  output logic [CNT_W-1:0]         served_cnt
);

  localparam int              ID_W    = $clog2(N_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  sched_state_e     state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  cur_id;
  logic [ID_W-1:0]  gnt_idx;
  logic [N_REQ-1:0] gnt;
  logic             grant_en;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign grant_en  = (state == IDLE) && !dp_rst;
  assign req_ready = grant_en ? gnt : '0;
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_id    = cur_id;

  // Datapath reset is held for exactly one edge beyond the block reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dp_rst <= 1'b1;
    else     dp_rst <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cur_id     <= '0;
      dp_in      <= '0;
      dp_mux_sel <= 1'b0;
      rsp_q      <= 1'b0;
      served_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_en && |req_valid) begin
            cur_id     <= gnt_idx;
            dp_in      <= req_in[gnt_idx*OPER_W +: OPER_W];
            dp_mux_sel <= req_reg[gnt_idx];
            state      <= DRIVE;
          end
        end
        DRIVE: begin
          if (dp_mux_sel) begin
            state <= WAIT;
          end else begin
            rsp_q <= dp_q;
            state <= RESP;
          end
        end
        WAIT: begin
          rsp_q <= dp_q;
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rr_ptr     <= (cur_id == LAST_ID) ? '0 : cur_id + ID_W'(1);
            served_cnt <= served_cnt + CNT_W'(1);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lut_ff_mux_sched.md
# lut_ff_mux_sched

Round-robin scheduler that shares a single `lut_ff_mux` datapath instance between `N_REQ` requesters. Each requester submits a 4-bit operand and a mode bit: combinational LUT output or registered FF output. The scheduler drives the datapath's `in`/`mux_sel`/`rst`, waits the mode-dependent latency, samples `Q`, and returns the result with the requester ID over a valid/ready response channel. It sits between the requesting logic and the `lut_ff_mux` instance.

## Interface
- `N_REQ`, 4 — number of requesters, 2..8
- `CNT_W`, 16 — width of the served-operation counter
- `clk`  in  1  — single clock, all state on rising edge
- `rst`  in  1  — asynchronous, active-high reset
- `req_valid`  in  N_REQ  — per-requester request valid
- `req_in`  in  N_REQ×4  — per-requester operand (index i at bits [4i+3:4i])
- `req_reg`  in  N_REQ  — per-requester mode: 1 = registered (mux_sel=1), 0 = combinational (mux_sel=0)
- `req_ready`  out  N_REQ  — one-hot accept strobe
- `dp_in`  out  4  — to datapath `in`
- `dp_mux_sel`  out  1  — to datapath `mux_sel`
- `dp_rst`  out  1  — to datapath `rst`
- `dp_q`  in  1  — from datapath `Q`
- `rsp_valid`  out  1  — response valid
- `rsp_ready`  in  1  — response accept
- `rsp_id`  out  $clog2(N_REQ)  — ID of the served requester
- `rsp_q`  out  1  — sampled `Q`
- `busy`  out  1  — high in any state other than IDLE
- `served_cnt`  out  CNT_W  — completed responses; wraps modulo 2^CNT_W

## Operation
- FSM states: IDLE, DRIVE, WAIT, RESP.
- **IDLE:**
  - If any `req_valid` is high, the round-robin arbiter picks the first valid requester at or after pointer `rr_ptr`.
  - `req_ready[g]` is high combinationally in this cycle; a request is accepted when `req_valid[g] && req_ready[g]`.
  - On accept, latch `g`, `req_in[g]` and `req_reg[g]`, then go to DRIVE.
- **DRIVE:**
  - Drive `dp_in` = latched operand and `dp_mux_sel` = latched mode.
  - Combinational mode: capture `dp_q` into `rsp_q` at the end of the cycle, then go to RESP.
  - Registered mode: go to WAIT.
- **WAIT** (registered mode only):
  - Keep `dp_in` and `dp_mux_sel` unchanged.
  - Capture `dp_q` into `rsp_q` at the end of the cycle, then go to RESP.
- **RESP:**
  - `rsp_valid` = 1; `rsp_id` and `rsp_q` are stable.
  - On `rsp_valid && rsp_ready`: `rr_ptr` ← (g+1) mod N_REQ, `served_cnt` += 1, go to IDLE.
- `dp_in` and `dp_mux_sel` hold their last driven values in IDLE and RESP.
- `req_ready` is all-zero outside IDLE. Requesters hold `req_valid` and their data stable until accepted.
- Only one operation is outstanding at a time; there is no request queuing.

## Timing
- Reset values:
  - FSM = IDLE, `req_ready` = 0, `dp_in` = 0, `dp_mux_sel` = 0, `dp_rst` = 1.
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_q` = 0, `busy` = 0, `rr_ptr` = 0, `served_cnt` = 0.
- `dp_rst` is a register:
  - set to 1 asynchronously with `rst`;
  - cleared on the first rising edge after `rst` deasserts.
  - While `dp_rst` = 1, IDLE does not grant.
- Latency, with the accept in cycle T:
  - combinational mode: `rsp_valid` first high in T+2;
  - registered mode: `rsp_valid` first high in T+3.
- Throughput with `rsp_ready` held high: 3 cycles per combinational operation, 4 per registered operation.
- Backpressure: RESP holds indefinitely while `rsp_ready` = 0, with outputs unchanged.
- Arbitration:
  - Ties are resolved by `rr_ptr`, starting the search at `rr_ptr` and wrapping from N_REQ-1 to 0.
  - A requester that deasserts `req_valid` before being accepted is simply skipped.
- `rst` asserted mid-operation: the operation is abandoned immediately and no response is issued. The requester must re-request.
- `served_cnt` wraps from 2^CNT_W−1 to 0 without a flag.

## Structure
- Package `lut_ff_mux_pkg`:
  - state enum `sched_state_e` (IDLE, DRIVE, WAIT, RESP);
  - `OPER_W` = 4;
  - `rsp_t` struct (id, q).
- Sub-module `rr_arbiter` (parameter N):
  - inputs `req`, `ptr`;
  - outputs one-hot `gnt` and encoded `gnt_idx`;
  - purely combinational.
- The top level instantiates `rr_arbiter` and the FSM. The `lut_ff_mux` instance lives outside this block.

## Test plan
- Reset release:
  - `dp_rst` stays 1 for one edge after `rst` falls.
  - No grant while `dp_rst` = 1, even with `req_valid` = 4'b1111.
  - All outputs are at their reset values.
- Single request, combinational mode: requester 2, `req_in` = 4'b0100, `req_reg` = 0.
  - `rsp_valid` at T+2, `rsp_id` = 2.
  - `rsp_q` equals the golden `lut_ff_mux` output for `in` = 4'b0100, `mux_sel` = 0.
- Single request, registered mode: requester 1, `req_in` = 4'b0001, `req_reg` = 1.
  - `rsp_valid` at T+3, `rsp_q` matches golden.
  - `dp_in` is held for both the DRIVE and WAIT cycles.
- Fairness: all 4 requesters valid continuously.
  - Grants occur in order 0,1,2,3,0.
  - `served_cnt` = 5 after five handshakes.
- Backpressure: `rsp_ready` = 0 for 6 cycles in RESP.
  - `rsp_valid`, `rsp_id` and `rsp_q` are stable.
  - No new `req_ready` is issued.
  - Completion happens on the cycle `rsp_ready` rises.
- Abort:
  - `rst` pulsed during WAIT → no response, FSM returns to IDLE, `served_cnt` = 0.
  - The next request completes normally.
- Random regression: 200 random requests against the golden model with randomized `rsp_ready`; zero mismatches.
